nios2_debug_cmd_sysclk: RTL and testbench

Parametrised system-clock-side command stage for the Nios II JTAG debug slave. It receives the update strobes of the virtual-JTAG shift chain, the instruction code and the shifted data word. It synchronises the strobes into `clk`, then latches the data word into `jdo` and decodes it into one-hot take_action / take_no_action pulses per instruction code. It generalises the fixed 2-bit-IR, 38-bit-SR command path in three ways: configurable widths, a configurable per-IR action-bit map, and an optional acknowledge handshake with overrun accounting toward the OCI, break and trace logic.

---
 rtl/nios2_debug_pkg.sv | 27 ++
 rtl/nios2_debug_sync_rise.sv | 34 +++
 rtl/nios2_debug_cmd_sysclk.sv | 131 +++++++++++++
 tb/tb_nios2_debug_cmd_sysclk.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// ============================================================================
// nios2_debug_pkg : shared types and helpers for the Nios II debug command stage
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package nios2_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // Fields packed IR3..IR0, 6 bits each: IR0->35, IR1->37, IR2->36, IR3->37.
  localparam logic [23:0] DEF_ACT_BIT_MAP = {6'd37, 6'd36, 6'd37, 6'd35};

  function automatic int unsigned act_bit_field(input logic [255:0] map,
                                                input int unsigned idx,
                                                input int unsigned fw);
    return 32'((map >> (idx * fw)) & ((256'(1) << fw) - 256'(1)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/nios2_debug_sync_rise.sv
// ============================================================================
// nios2_debug_sync_rise : multi-flop synchroniser followed by a rise detector
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nios2_debug_sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/nios2_debug_cmd_sysclk.sv
// ============================================================================
// nios2_debug_cmd_sysclk : system-clock command latch/decode for the JTAG debug slave
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nios2_debug_cmd_sysclk
  import nios2_debug_pkg::*;
#(
  parameter  int SR_W        = 38,
  parameter  int IR_W        = 2,
  parameter  int SYNC_STAGES = 2,
  localparam int NCMD        = 2 ** IR_W,
  localparam int SEL_W       = $clog2(SR_W),
  parameter  logic [NCMD*SEL_W-1:0] ACT_BIT_MAP = (NCMD*SEL_W)'(DEF_ACT_BIT_MAP),
  parameter  bit REQUIRE_ACK = 1'b0,
  parameter  int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vs_udr,
  input  logic            vs_uir,
  input  logic [IR_W-1:0] ir_in,
  input  logic [SR_W-1:0] sr,
  input  logic            cmd_ack,
  output logic [SR_W-1:0] jdo,
  output logic [IR_W-1:0] cmd_ir,
  output logic [NCMD-1:0] take_action,
  output logic [NCMD-1:0] take_no_action,
  output logic            cmd_pending,
  output logic            overrun,
  output logic [CNT_W-1:0] overrun_cnt
);

  logic udr_rise;
  logic uir_rise;

  nios2_debug_sync_rise #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk(clk), .reset(reset), .async_in(vs_udr), .rise(udr_rise)
  );

  nios2_debug_sync_rise #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk(clk), .reset(reset), .async_in(vs_uir), .rise(uir_rise)
  );

  state_t          state;
  state_t          next_state;
  logic [IR_W-1:0] ir_lat;
  logic            load;
  logic            drop;
  logic [NCMD-1:0] sel_bit;

  for (genvar i = 0; i < NCMD; i++) begin : g_act_sel
    localparam logic [SEL_W-1:0] SEL = SEL_W'(act_bit_field(256'(ACT_BIT_MAP), i, SEL_W));
    assign sel_bit[i] = jdo[SEL];
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (udr_rise) begin
          load       = 1'b1;
          next_state = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (REQUIRE_ACK) begin
          drop       = udr_rise;
          next_state = ST_PENDING;
        end else if (udr_rise) begin
          load       = 1'b1;
          next_state = ST_FIRE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_PENDING: begin
        // A simultaneous acknowledge frees the slot for the arriving command.
        if (cmd_ack && udr_rise) begin
          load       = 1'b1;
          next_state = ST_FIRE;
        end else if (cmd_ack) begin
          next_state = ST_IDLE;
        end else if (udr_rise) begin
          drop       = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (state == ST_FIRE) begin
      if (sel_bit[cmd_ir]) take_action[cmd_ir]    = 1'b1;
      else                 take_no_action[cmd_ir] = 1'b1;
    end
  end

  assign cmd_pending = (state == ST_PENDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir_lat      <= '0;
      jdo         <= '0;
      cmd_ir      <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state <= next_state;
      if (uir_rise) ir_lat <= ir_in;
      if (load) begin
        jdo    <= sr;
        cmd_ir <= ir_lat;
      end
      if (drop) begin
        overrun <= 1'b1;
        if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios2_debug_cmd_sysclk.sv
// ============================================================================
// tb_nios2_debug_cmd_sysclk : directed bench for a default instance and an ack/CNT_W=2 instance
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nios2_debug_cmd_sysclk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, vs_udr, vs_uir, cmd_ack;
  logic [1:0]  ir_in;
  logic [37:0] sr;

  logic [37:0] a_jdo, b_jdo;
  logic [1:0]  a_cmd_ir, b_cmd_ir;
  logic [3:0]  a_act, a_noact, b_act, b_noact;
  logic        a_pend, a_ovr, b_pend, b_ovr;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [37:0] SR1 = 38'h2A_DEAD_BEEF;
  localparam logic [37:0] SR2 = 38'h2B_0000_0001;
  localparam logic [37:0] SR3 = 38'h10_0000_00FF;
  localparam logic [37:0] SR4 = 38'h08_0000_0000;
  localparam logic [37:0] W1  = 38'h20_0000_0011;
  localparam logic [37:0] W2  = 38'h00_0000_0022;
  localparam logic [37:0] W3  = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] W4  = 38'h28_0000_0044;

  nios2_debug_cmd_sysclk dut_a (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in),
    .sr(sr), .cmd_ack(cmd_ack), .jdo(a_jdo), .cmd_ir(a_cmd_ir),
    .take_action(a_act), .take_no_action(a_noact), .cmd_pending(a_pend),
    .overrun(a_ovr), .overrun_cnt(a_cnt)
  );

  nios2_debug_cmd_sysclk #(.REQUIRE_ACK(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in),
    .sr(sr), .cmd_ack(cmd_ack), .jdo(b_jdo), .cmd_ir(b_cmd_ir),
    .take_action(b_act), .take_no_action(b_noact), .cmd_pending(b_pend),
    .overrun(b_ovr), .overrun_cnt(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  task automatic udr_fall();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ack = 1'b0;
    ir_in = 2'd0; sr = '0;
    repeat (2) tick();
    chk("rst_a", {6'd0, a_jdo, a_cmd_ir, a_act, a_noact, a_pend, a_ovr, a_cnt}, 64'd0);
    chk("rst_b", {12'd0, b_jdo, b_cmd_ir, b_act, b_noact, b_pend, b_ovr, b_cnt}, 64'd0);
    reset = 1'b0;
    tick();

    // IR1 selects bit 37 -> action
    load_ir(2'd1);
    sr = SR1; vs_udr = 1'b1;
    tick(); chk("t1_e1_act", a_act, 4'b0000);
    tick(); chk("t1_e2_act", a_act, 4'b0000);
    tick(); chk("t1_e3_act", a_act, 4'b0010);
    chk("t1_jdo", a_jdo, SR1);
    chk("t1_noact", a_noact, 4'b0000);
    chk("t1_cmd_ir", a_cmd_ir, 2'd1);
    tick(); chk("t1_e4_act", a_act, 4'b0000);
    chk("t1_no_pend", a_pend, 1'b0);
    udr_fall();

    // IR2 selects bit 36 -> no-action, then action
    load_ir(2'd2);
    sr = SR2; vs_udr = 1'b1;
    repeat (3) tick();
    chk("t2_noact", a_noact, 4'b0100);
    chk("t2_act", a_act, 4'b0000);
    chk("t2_cmd_ir", a_cmd_ir, 2'd2);
    tick(); udr_fall();
    sr = SR3; vs_udr = 1'b1;
    repeat (3) tick();
    chk("t3_act", a_act, 4'b0100);
    chk("t3_jdo", a_jdo, SR3);
    tick(); udr_fall();

    // IR0 selects bit 35
    load_ir(2'd0);
    sr = SR4; vs_udr = 1'b1;
    repeat (3) tick();
    chk("t4_act", a_act, 4'b0001);
    tick(); udr_fall();

    reset = 1'b1; tick(); reset = 1'b0; tick();

    // Acknowledge-mode instance
    load_ir(2'd3);
    sr = W1; vs_udr = 1'b1;
    repeat (3) tick();
    chk("b1_act", b_act, 4'b1000);
    chk("b1_jdo", b_jdo, W1);
    tick(); chk("b1_pend", b_pend, 1'b1);
    udr_fall();

    sr = W2; vs_udr = 1'b1;
    tick(); tick();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("col_jdo", b_jdo, W2);
    chk("col_noact", b_noact, 4'b1000);
    chk("col_cnt", b_cnt, 2'd0);
    chk("col_ovr", b_ovr, 1'b0);
    chk("col_pend_fire", b_pend, 1'b0);
    tick(); chk("col_pend", b_pend, 1'b1);
    udr_fall();

    sr = W3; vs_udr = 1'b1;
    repeat (3) tick();
    chk("drop_pulse", {b_act, b_noact}, 8'd0);
    chk("drop_ovr", b_ovr, 1'b1);
    chk("drop_cnt", b_cnt, 2'd1);
    chk("drop_jdo", b_jdo, W2);
    chk("drop_pend", b_pend, 1'b1);
    tick(); udr_fall();

    for (int k = 0; k < 2; k++) begin
      vs_udr = 1'b1; repeat (4) tick(); udr_fall();
    end
    chk("sat3_cnt", b_cnt, 2'd3);
    for (int k = 0; k < 2; k++) begin
      vs_udr = 1'b1; repeat (4) tick(); udr_fall();
    end
    chk("sat5_cnt", b_cnt, 2'd3);

    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    chk("ack_pend", b_pend, 1'b0);
    chk("ack_ovr_sticky", b_ovr, 1'b1);
    tick();

    // Reset while pending with vs_udr held high
    sr = W4; vs_udr = 1'b1;
    repeat (4) tick();
    chk("rp_pend", b_pend, 1'b1);
    reset = 1'b1;
    tick();
    chk("rp_rst_b", {12'd0, b_jdo, b_cmd_ir, b_act, b_noact, b_pend, b_ovr, b_cnt}, 64'd0);
    chk("rp_rst_a", {6'd0, a_jdo, a_cmd_ir, a_act, a_noact, a_pend, a_ovr, a_cnt}, 64'd0);
    reset = 1'b0;
    tick(); chk("rp_e1", {b_act, b_noact}, 8'd0);
    tick(); chk("rp_e2", {b_act, b_noact}, 8'd0);
    tick(); chk("rp_e3_b", {b_act, b_noact}, {4'b0001, 4'b0000});
    chk("rp_e3_a", {a_act, a_noact}, {4'b0001, 4'b0000});
    chk("rp_e3_jdo", b_jdo, W4);
    tick(); chk("rp_e4", {b_act, b_noact, a_act, a_noact}, 16'd0);
    tick(); chk("rp_e5", {b_act, b_noact, a_act, a_noact}, 16'd0);
    vs_udr = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
